// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIXUP,
        DONE
    } div_state_t;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 5;

    // Two's-complement magnitude, negating only signed negative operands.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_cmp.sv
// rtl/mdu_cmp.sv - 32-bit signed/unsigned less-than comparator
module mdu_cmp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic        lt
);

    always_comb begin
        lt = 1'b0;
        if (is_signed)
            lt = ($signed(a) < $signed(b));
        else
            lt = (a < b);
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit restoring divider for DIV/DIVU
module div_unit
    import mdu_pkg::*;
#(
    parameter logic [31:0] DIVZ_QUO             = 32'hFFFF_FFFF,
    parameter bit          DIVZ_REM_IS_DIVIDEND = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      r_work;
    logic [31:0]      q_work;
    logic [31:0]      d_mag;
    logic             neg_dvd;
    logic             neg_dvs;

    logic [31:0]      shifted;
    logic [31:0]      diff;
    logic             lt;
    logic             ge;

    assign shifted = {r_work[30:0], q_work[31]};
    assign diff    = shifted - d_mag;

    mdu_cmp u_cmp (
        .a         (shifted),
        .b         (d_mag),
        .is_signed (1'b0),
        .lt        (lt)
    );

    // r_work[31] stands in for the 33rd bit of the shifted remainder.
    assign ge = r_work[31] | ~lt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r_work      <= '0;
            q_work      <= '0;
            d_mag       <= '0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        neg_dvd <= is_signed & dividend[31];
                        neg_dvs <= is_signed & divisor[31];
                        d_mag   <= mag32(divisor, is_signed);
                        r_work  <= '0;
                        q_work  <= mag32(dividend, is_signed);
                        cnt     <= '0;
                        if (divisor == 32'd0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= DIVZ_QUO;
                            remainder   <= DIVZ_REM_IS_DIVIDEND ? dividend : 32'd0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= ITER;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    if (ge) begin
                        r_work <= diff;
                        q_work <= {q_work[30:0], 1'b1};
                    end else begin
                        r_work <= shifted;
                        q_work <= {q_work[30:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_STEPS - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    quotient  <= (neg_dvd ^ neg_dvs) ? (~q_work + 32'd1) : q_work;
                    remainder <= neg_dvd ? (~r_work + 32'd1) : r_work;
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
